// File: rtl/tdp_ram_pkg.sv
// -----------------------------------------------------------------------------
// tdp_ram_pkg
// Shared definitions for the byte-writable true dual-port RAM:
//   - ramState_e   : init/clear state machine encoding (RESET -> CLEAR -> READY)
//   - READ_LAT_*   : the two supported read latencies
//   - calcNumBytes : number of byte-enable lanes for a given word/lane width
//   - isLegalLatency : true for a supported READ_LATENCY value
// No ports (package).
// -----------------------------------------------------------------------------
package tdp_ram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } ramState_e;

  localparam int READ_LAT_ONE = 32'sd1;
  localparam int READ_LAT_TWO = 32'sd2;

  function automatic int calcNumBytes(input int dataWidth, input int byteWidth);
    return dataWidth / byteWidth;
  endfunction

  function automatic logic isLegalLatency(input int latency);
    return (latency == READ_LAT_ONE) || (latency == READ_LAT_TWO);
  endfunction

endpackage

// File: rtl/tdp_ram_core.sv
// -----------------------------------------------------------------------------
// tdp_ram_core
// Plain storage array with two byte-enable write ports and two registered read
// ports. No reset on the array or the read registers so that synthesis maps it
// onto block RAM. Reads return the pre-write contents on a same-cycle write.
// Callers must keep enabled addresses below NUM_ENTRIES.
// Ports:
//   clock        : single clock
//   aWe / bWe    : per-lane write enables
//   aAddr/bAddr  : word address (shared by read and write of that port)
//   aDin / bDin  : write data
//   aRe  / bRe   : read enable; the read register holds when low
//   aDout/bDout  : registered read data
// -----------------------------------------------------------------------------
module tdp_ram_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 2048,
  parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  parameter int BYTE_WIDTH  = 8,
  parameter int NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic [NUM_BYTES-1:0]  aWe,
  input  logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0] aDin,
  input  logic                  aRe,
  output logic [DATA_WIDTH-1:0] aDout,
  input  logic [NUM_BYTES-1:0]  bWe,
  input  logic [ADDR_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0] bDin,
  input  logic                  bRe,
  output logic [DATA_WIDTH-1:0] bDout
);

  logic [DATA_WIDTH-1:0] mem_r [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] aDout_r;
  logic [DATA_WIDTH-1:0] bDout_r;

  // Byte-lane writes; port A is applied last so it owns any lane both ports set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (bWe[i]) begin
        mem_r[bAddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bDin[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (aWe[i]) begin
        mem_r[aAddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= aDin[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Port A read register, holds its value when no read is issued.
  always_ff @(posedge clock) begin
    if (aRe) begin
      aDout_r <= mem_r[aAddr];
    end
  end

  // Port B read register, holds its value when no read is issued.
  always_ff @(posedge clock) begin
    if (bRe) begin
      bDout_r <= mem_r[bAddr];
    end
  end

  assign aDout = aDout_r;
  assign bDout = bDout_r;

endmodule

// File: rtl/tdp_ram_bytewise.sv
// -----------------------------------------------------------------------------
// tdp_ram_bytewise
// Single-clock true dual-port RAM with per-byte write enables, read latency of
// 1 or 2 cycles, per-port read-valid strobes, same-address collision handling
// and an optional zero-fill sweep after reset.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   init_done               : requests are accepted while high
//   collision               : one-cycle pulse after a same-address access with a write
//   portX_en / portX_we     : request enable / byte write enables (all zero = read)
//   portX_addr / portX_din  : word address / write data
//   portX_dout              : read data, held until the next read result
//   portX_dout_valid        : one-cycle strobe when portX_dout carries a new result
// -----------------------------------------------------------------------------
module tdp_ram_bytewise
  import tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_ENTRIES    = 2048,
  parameter int ADDR_WIDTH     = $clog2(NUM_ENTRIES),
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  output logic                                          init_done,
  output logic                                          collision,
  input  logic                                          portA_en,
  input  logic [calcNumBytes(DATA_WIDTH, BYTE_WIDTH)-1:0] portA_we,
  input  logic [ADDR_WIDTH-1:0]                         portA_addr,
  input  logic [DATA_WIDTH-1:0]                         portA_din,
  output logic [DATA_WIDTH-1:0]                         portA_dout,
  output logic                                          portA_dout_valid,
  input  logic                                          portB_en,
  input  logic [calcNumBytes(DATA_WIDTH, BYTE_WIDTH)-1:0] portB_we,
  input  logic [ADDR_WIDTH-1:0]                         portB_addr,
  input  logic [DATA_WIDTH-1:0]                         portB_din,
  output logic [DATA_WIDTH-1:0]                         portB_dout,
  output logic                                          portB_dout_valid
);

  localparam int                    NUM_BYTES = calcNumBytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH:0]   ENTRIES_W = (ADDR_WIDTH+1)'(NUM_ENTRIES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);
  // Unsupported latency values fall back to a single cycle.
  localparam logic USE_LAT2 = isLegalLatency(READ_LATENCY) && (READ_LATENCY == READ_LAT_TWO);
  localparam logic DO_CLEAR = (CLEAR_ON_RESET != 0);

  ramState_e             state_r;
  logic [ADDR_WIDTH-1:0] clearAddr_r;
  logic                  initDone_r;
  logic                  collision_r;

  logic accA_s, accB_s, inRangeA_s, inRangeB_s, isWrA_s, isWrB_s;
  logic rdAccA_s, rdAccB_s, wrAccA_s, wrAccB_s, sameAddr_s, clearing_s;

  logic [NUM_BYTES-1:0]  coreWeA_s, coreWeB_s;
  logic [ADDR_WIDTH-1:0] coreAddrA_s, coreAddrB_s;
  logic [DATA_WIDTH-1:0] coreDinA_s, coreDinB_s;
  logic                  coreReA_s, coreReB_s;
  logic [DATA_WIDTH-1:0] coreDoutA_s, coreDoutB_s;

  logic                  vldA1_r, vldB1_r, vldA2_r, vldB2_r;
  logic                  zeroA_r, zeroB_r;
  logic [DATA_WIDTH-1:0] doutA2_r, doutB2_r;
  logic [DATA_WIDTH-1:0] stage1A_s, stage1B_s;

  // Request qualification: nothing is accepted until init_done.
  assign accA_s     = portA_en & initDone_r;
  assign accB_s     = portB_en & initDone_r;
  assign inRangeA_s = ({1'b0, portA_addr} < ENTRIES_W);
  assign inRangeB_s = ({1'b0, portB_addr} < ENTRIES_W);
  assign isWrA_s    = |portA_we;
  assign isWrB_s    = |portB_we;
  assign rdAccA_s   = accA_s & ~isWrA_s;
  assign rdAccB_s   = accB_s & ~isWrB_s;
  assign wrAccA_s   = accA_s & isWrA_s & inRangeA_s;
  assign wrAccB_s   = accB_s & isWrB_s & inRangeB_s;
  assign sameAddr_s = accA_s & accB_s & inRangeA_s & (portA_addr == portB_addr);

  // The first sweep write happens on the very first edge after release so the
  // sweep costs exactly NUM_ENTRIES cycles; reset_n keeps the array untouched
  // while reset is still held.
  assign clearing_s = DO_CLEAR &&
                      ((state_r == ST_CLEAR) || ((state_r == ST_RESET) && reset_n));

  // Steer sweep writes, merged same-address writes or independent writes into the core.
  always_comb begin
    coreWeA_s   = '0;
    coreAddrA_s = portA_addr;
    coreDinA_s  = portA_din;
    coreWeB_s   = '0;
    coreAddrB_s = portB_addr;
    coreDinB_s  = portB_din;
    if (clearing_s) begin
      coreWeA_s   = '1;
      coreAddrA_s = clearAddr_r;
      coreDinA_s  = '0;
    end else if (sameAddr_s && wrAccA_s && wrAccB_s) begin
      // Single merged write: A's lanes win, B fills lanes A leaves untouched.
      coreWeA_s = portA_we | portB_we;
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (portA_we[i]) begin
          coreDinA_s[i*BYTE_WIDTH +: BYTE_WIDTH] = portA_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end else begin
          coreDinA_s[i*BYTE_WIDTH +: BYTE_WIDTH] = portB_din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end else begin
      coreWeA_s = wrAccA_s ? portA_we : '0;
      coreWeB_s = wrAccB_s ? portB_we : '0;
    end
  end

  // Out-of-range reads never touch the array; their zero result comes from the mask flag.
  assign coreReA_s = rdAccA_s & inRangeA_s;
  assign coreReB_s = rdAccB_s & inRangeB_s;

  tdp_ram_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH),
    .NUM_BYTES   (NUM_BYTES)
  ) uCore (
    .clock (clock),
    .aWe   (coreWeA_s),
    .aAddr (coreAddrA_s),
    .aDin  (coreDinA_s),
    .aRe   (coreReA_s),
    .aDout (coreDoutA_s),
    .bWe   (coreWeB_s),
    .bAddr (coreAddrB_s),
    .bDin  (coreDinB_s),
    .bRe   (coreReB_s),
    .bDout (coreDoutB_s)
  );

  // Init state machine: optional zero sweep, then READY with init_done set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RESET;
      clearAddr_r <= '0;
      initDone_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (DO_CLEAR) begin
            if (clearAddr_r == LAST_ADDR) begin
              state_r    <= ST_READY;
              initDone_r <= 1'b1;
            end else begin
              state_r     <= ST_CLEAR;
              clearAddr_r <= clearAddr_r + ADDR_WIDTH'(1);
            end
          end else begin
            state_r    <= ST_READY;
            initDone_r <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clearAddr_r == LAST_ADDR) begin
            state_r    <= ST_READY;
            initDone_r <= 1'b1;
          end else begin
            clearAddr_r <= clearAddr_r + ADDR_WIDTH'(1);
          end
        end
        ST_READY: begin
          initDone_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_RESET;
          clearAddr_r <= '0;
          initDone_r  <= 1'b0;
        end
      endcase
    end
  end

  // Collision pulse for same in-range address with at least one write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      collision_r <= 1'b0;
    end else begin
      collision_r <= sameAddr_s & (isWrA_s | isWrB_s);
    end
  end

  // First read stage: valid strobe plus a flag that blanks the core output
  // after reset and for out-of-range reads (the core register itself is unreset).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vldA1_r <= 1'b0;
      vldB1_r <= 1'b0;
      zeroA_r <= 1'b1;
      zeroB_r <= 1'b1;
    end else begin
      vldA1_r <= rdAccA_s;
      vldB1_r <= rdAccB_s;
      if (rdAccA_s) begin
        zeroA_r <= ~inRangeA_s;
      end
      if (rdAccB_s) begin
        zeroB_r <= ~inRangeB_s;
      end
    end
  end

  assign stage1A_s = zeroA_r ? '0 : coreDoutA_s;
  assign stage1B_s = zeroB_r ? '0 : coreDoutB_s;

  // Second read stage, only observed when READ_LATENCY is 2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vldA2_r  <= 1'b0;
      vldB2_r  <= 1'b0;
      doutA2_r <= '0;
      doutB2_r <= '0;
    end else begin
      vldA2_r <= vldA1_r;
      vldB2_r <= vldB1_r;
      if (vldA1_r) begin
        doutA2_r <= stage1A_s;
      end
      if (vldB1_r) begin
        doutB2_r <= stage1B_s;
      end
    end
  end

  assign init_done        = initDone_r;
  assign collision        = collision_r;
  assign portA_dout       = USE_LAT2 ? doutA2_r : stage1A_s;
  assign portB_dout       = USE_LAT2 ? doutB2_r : stage1B_s;
  assign portA_dout_valid = USE_LAT2 ? vldA2_r : vldA1_r;
  assign portB_dout_valid = USE_LAT2 ? vldB2_r : vldB1_r;

endmodule

// File: tb/tb_tdp_ram_bytewise.sv
// -----------------------------------------------------------------------------
// tb_tdp_ram_bytewise
// Directed bench for tdp_ram_bytewise. Two instances share clock and reset:
//   d16 : 16 entries, read latency 1, clear sweep enabled
//   d12 : 12 entries, read latency 2, clear sweep disabled
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tdp_ram_bytewise;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // d16 signals
  logic        aEn16, bEn16;
  logic [3:0]  aWe16, bWe16, aAddr16, bAddr16;
  logic [31:0] aDin16, bDin16;
  logic [31:0] aDout16, bDout16;
  logic        aVld16, bVld16, init16, col16;
  // d12 signals
  logic        aEn12, bEn12;
  logic [3:0]  aWe12, bWe12, aAddr12, bAddr12;
  logic [31:0] aDin12, bDin12;
  logic [31:0] aDout12, bDout12;
  logic        aVld12, bVld12, init12, col12;

  int nTests = 0;
  int nFail  = 0;
  int cnt;
  logic sawV;
  int sAddr;
  int clrList [4] = '{10, 3, 7, 0};

  tdp_ram_bytewise #(.DATA_WIDTH(32), .NUM_ENTRIES(16), .BYTE_WIDTH(8),
                     .READ_LATENCY(1), .CLEAR_ON_RESET(1)) d16 (
    .clock(clk), .reset_n(rst_n), .init_done(init16), .collision(col16),
    .portA_en(aEn16), .portA_we(aWe16), .portA_addr(aAddr16), .portA_din(aDin16),
    .portA_dout(aDout16), .portA_dout_valid(aVld16),
    .portB_en(bEn16), .portB_we(bWe16), .portB_addr(bAddr16), .portB_din(bDin16),
    .portB_dout(bDout16), .portB_dout_valid(bVld16)
  );

  tdp_ram_bytewise #(.DATA_WIDTH(32), .NUM_ENTRIES(12), .BYTE_WIDTH(8),
                     .READ_LATENCY(2), .CLEAR_ON_RESET(0)) d12 (
    .clock(clk), .reset_n(rst_n), .init_done(init12), .collision(col12),
    .portA_en(aEn12), .portA_we(aWe12), .portA_addr(aAddr12), .portA_din(aDin12),
    .portA_dout(aDout12), .portA_dout_valid(aVld12),
    .portB_en(bEn12), .portB_we(bWe12), .portB_addr(bAddr12), .portB_din(bDin12),
    .portB_dout(bDout12), .portB_dout_valid(bVld12)
  );

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    aEn16 = 1'b0; bEn16 = 1'b0; aWe16 = 4'h0; bWe16 = 4'h0;
    aAddr16 = 4'h0; bAddr16 = 4'h0; aDin16 = 32'h0; bDin16 = 32'h0;
    aEn12 = 1'b0; bEn12 = 1'b0; aWe12 = 4'h0; bWe12 = 4'h0;
    aAddr12 = 4'h0; bAddr12 = 4'h0; aDin12 = 32'h0; bDin12 = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chkb("rst_init16", init16, 1'b0);
    chkb("rst_col16", col16, 1'b0);
    chkw("rst_doutA16", aDout16, 32'h0);
    chkb("rst_vldB16", bVld16, 1'b0);
    chkb("rst_init12", init12, 1'b0);
    chkw("rst_doutB12", bDout12, 32'h0);

    // Clear sweep with a read pending on port B the whole time
    rst_n = 1'b1; bEn16 = 1'b1; bAddr16 = 4'd3;
    @(negedge clk);
    chkb("init12_first_edge", init12, 1'b1);
    cnt = 1;
    sawV = bVld16;
    while (!init16 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      sawV = sawV | bVld16;
    end
    chkw("sweep_cycles", cnt, 32'd16);
    chkb("no_valid_in_sweep", sawV, 1'b0);

    // Read every address back-to-back on port B
    for (int i = 0; i < 16; i++) begin
      bAddr16 = 4'(i);
      @(negedge clk);
      chkb("clear_read_vld", bVld16, 1'b1);
      chkw("clear_read_data", bDout16, 32'h0);
    end
    bEn16 = 1'b0;

    // Byte enables on both instances
    aEn16 = 1'b1; aWe16 = 4'hF; aAddr16 = 4'd5; aDin16 = 32'hAABBCCDD;
    aEn12 = 1'b1; aWe12 = 4'hF; aAddr12 = 4'd5; aDin12 = 32'hAABBCCDD;
    @(negedge clk);
    chkb("wr_no_valid16", aVld16, 1'b0);
    aWe16 = 4'b0101; aDin16 = 32'h11223344;
    aWe12 = 4'b0101; aDin12 = 32'h11223344;
    @(negedge clk);
    aEn16 = 1'b0; aEn12 = 1'b0; aWe16 = 4'h0; aWe12 = 4'h0;
    bEn16 = 1'b1; bAddr16 = 4'd5; bEn12 = 1'b1; bAddr12 = 4'd5;
    @(negedge clk);
    bEn16 = 1'b0; bEn12 = 1'b0;
    chkw("be_data_lat1", bDout16, 32'hAA22CC44);
    chkb("be_vld_lat1", bVld16, 1'b1);
    chkb("lat2_not_yet", bVld12, 1'b0);
    @(negedge clk);
    chkb("vld_pulse16", bVld16, 1'b0);
    chkw("be_data_lat2", bDout12, 32'hAA22CC44);
    chkb("be_vld_lat2", bVld12, 1'b1);
    @(negedge clk);
    chkb("vld_pulse12", bVld12, 1'b0);
    chkw("hold_dout16", bDout16, 32'hAA22CC44);

    // Read/write collision on d16
    aEn16 = 1'b1; aWe16 = 4'hF; aAddr16 = 4'd7; aDin16 = 32'h1;
    @(negedge clk);
    chkb("wr_only_no_col", col16, 1'b0);
    aDin16 = 32'h2; bEn16 = 1'b1; bAddr16 = 4'd7;
    @(negedge clk);
    aEn16 = 1'b0; aWe16 = 4'h0; bEn16 = 1'b0;
    chkw("rw_old_data", bDout16, 32'h1);
    chkb("rw_vld", bVld16, 1'b1);
    chkb("rw_col", col16, 1'b1);
    @(negedge clk);
    chkb("rw_col_one_cycle", col16, 1'b0);
    bEn16 = 1'b1;
    @(negedge clk);
    bEn16 = 1'b0;
    chkw("rw_new_data", bDout16, 32'h2);

    // Write/write merge on d16
    aEn16 = 1'b1; aWe16 = 4'b0011; aAddr16 = 4'd3; aDin16 = 32'h000000FF;
    bEn16 = 1'b1; bWe16 = 4'b1110; bAddr16 = 4'd3; bDin16 = 32'hFFFF0000;
    @(negedge clk);
    aEn16 = 1'b0; aWe16 = 4'h0; bEn16 = 1'b0; bWe16 = 4'h0;
    chkb("ww_col", col16, 1'b1);
    aEn16 = 1'b1;
    @(negedge clk);
    aEn16 = 1'b0;
    chkw("ww_merge", aDout16, 32'hFFFF00FF);

    // Both ports read the same address
    aEn16 = 1'b1; aAddr16 = 4'd5; bEn16 = 1'b1; bAddr16 = 4'd5;
    @(negedge clk);
    aEn16 = 1'b0; bEn16 = 1'b0;
    chkw("rr_dataA", aDout16, 32'hAA22CC44);
    chkw("rr_dataB", bDout16, 32'hAA22CC44);
    chkb("rr_no_col", col16, 1'b0);

    // Streaming: fill 0..7, then read with a write slotted in
    bEn16 = 1'b1; bWe16 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bAddr16 = 4'(i);
      bDin16 = 32'h100 + i;
      @(negedge clk);
    end
    bEn16 = 1'b0; bWe16 = 4'h0;
    aEn16 = 1'b1;
    for (int s = 0; s < 9; s++) begin
      sAddr = (s < 4) ? s : s - 1;
      if (s == 4) begin
        aWe16 = 4'hF; aAddr16 = 4'd10; aDin16 = 32'hDEADBEEF;
      end else begin
        aWe16 = 4'h0; aAddr16 = 4'(sAddr);
      end
      @(negedge clk);
      if (s == 4) begin
        chkb("stream_wr_no_valid", aVld16, 1'b0);
        chkw("stream_wr_hold", aDout16, 32'h103);
      end else begin
        chkb("stream_vld", aVld16, 1'b1);
        chkw("stream_data", aDout16, 32'h100 + sAddr);
      end
    end
    aWe16 = 4'h0; aAddr16 = 4'd10;
    @(negedge clk);
    aEn16 = 1'b0;
    chkw("stream_written", aDout16, 32'hDEADBEEF);

    // Latency-2 streaming on d12
    bEn12 = 1'b1; bWe12 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bAddr12 = 4'(i);
      bDin12 = 32'h200 + i;
      @(negedge clk);
    end
    bEn12 = 1'b0; bWe12 = 4'h0;
    for (int s = 0; s < 6; s++) begin
      aEn12 = (s < 4);
      aAddr12 = 4'(s);
      @(negedge clk);
      chkb("lat2_stream_vld", aVld12, (s >= 1 && s <= 4));
      if (s >= 1 && s <= 4) begin
        chkw("lat2_stream_data", aDout12, 32'h200 + s - 1);
      end
    end
    aEn12 = 1'b0;

    // Asynchronous reset during operation with a result on the outputs
    aEn16 = 1'b1; aAddr16 = 4'd10;
    @(posedge clk);
    #2;
    aEn16 = 1'b0;
    chkb("pre_rst_vld", aVld16, 1'b1);
    chkw("pre_rst_data", aDout16, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chkb("async_init_drop", init16, 1'b0);
    chkb("async_vld_drop", aVld16, 1'b0);
    chkw("async_dout_drop", aDout16, 32'h0);
    chkb("async_init12", init12, 1'b0);
    chkw("async_dout12", aDout12, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset again at sweep address 9, then the sweep must restart from 0
    repeat (9) @(negedge clk);
    chkb("mid_sweep_busy", init16, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!init16 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chkw("resweep_cycles", cnt, 32'd16);

    // Previously written words are zero after the sweep
    bEn16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bAddr16 = 4'(clrList[i]);
      @(negedge clk);
      chkb("resweep_vld", bVld16, 1'b1);
      chkw("resweep_zero", bDout16, 32'h0);
    end
    bEn16 = 1'b0;

    // d12 keeps its contents across reset; out-of-range read returns 0 with valid
    bEn12 = 1'b1; bAddr12 = 4'd5;
    @(negedge clk);
    bAddr12 = 4'd13;
    @(negedge clk);
    bEn12 = 1'b0;
    chkw("retain_after_rst", bDout12, 32'hAA22CC44);
    chkb("retain_vld", bVld12, 1'b1);
    @(negedge clk);
    chkw("oor_read_zero", bDout12, 32'h0);
    chkb("oor_read_vld", bVld12, 1'b1);

    // Same out-of-range address written and read: no collision
    aEn12 = 1'b1; aWe12 = 4'hF; aAddr12 = 4'd12; aDin12 = 32'h12345678;
    bEn12 = 1'b1; bAddr12 = 4'd12;
    @(negedge clk);
    aEn12 = 1'b0; aWe12 = 4'h0; bEn12 = 1'b0;
    chkb("oor_no_col", col12, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/tdp_ram_bytewise.md
Name: tdp_ram_bytewise

Overview:
Parametrised true dual-port, single-clock RAM; next generation of the team's dual-port buffer RAM. Adds per-byte write enables, selectable read latency (1 or 2), per-port read-valid strobes and same-address collision detection/resolution. Also adds an optional hardware clear sweep after reset, signalled by init_done. Used wherever packet buffers or context tables are shared between two engines.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
NUM_ENTRIES, 2048, number of words; need not be a power of two
ADDR_WIDTH, $clog2(NUM_ENTRIES), address width
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
READ_LATENCY, 1, cycles from accepted read to dout_valid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every entry after reset before accepting requests

Ports:
clock  in  1  single clock for both ports
reset_n  in  1  asynchronous, active-low reset
init_done  out  1  high when requests are accepted
collision  out  1  one-cycle pulse: same-address access on both ports with at least one write
portA_en  in  1  port A request enable
portA_we  in  NUM_BYTES  port A byte write enables; all zero = read
portA_addr  in  ADDR_WIDTH  port A word address
portA_din  in  DATA_WIDTH  port A write data
portA_dout  out  DATA_WIDTH  port A read data
portA_dout_valid  out  1  port A read data valid strobe
portB_en, portB_we, portB_addr, portB_din, portB_dout, portB_dout_valid: same as port A, for port B

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: init_done=0, collision=0, both dout=0, both dout_valid=0.
  - Read pipelines are flushed and the clear counter is zeroed.
  - Memory contents are not reset by the assertion itself.
- FSM states: RESET -> CLEAR -> READY.
  - CLEAR_ON_RESET=1: CLEAR writes 0 to address 0..NUM_ENTRIES-1, one entry per cycle, then enters READY. init_done rises on the cycle after the write to the last address. Sweep takes NUM_ENTRIES cycles.
  - CLEAR_ON_RESET=0: CLEAR is skipped. init_done rises on the first clock edge after reset_n deasserts.
  - While init_done=0, port requests are ignored entirely: no write, no dout_valid, no collision.
- Reset asserted mid-sweep or mid-operation: the FSM returns to RESET immediately and the sweep restarts from address 0 after deassertion. In-flight reads are discarded.
- Request acceptance: a request is accepted when en=1 and init_done=1.
- Read (we==0):
  - dout carries mem[addr] READ_LATENCY cycles after acceptance.
  - dout_valid is high for exactly that one cycle.
  - dout holds its last value until the next read result; it is never cleared on idle cycles.
- Write (we!=0), no-change semantics:
  - Byte lane i updates only if we[i]=1.
  - dout and dout_valid of the writing port are unaffected, apart from earlier reads still in the pipeline.
  - A write is visible to a read on either port accepted on the next cycle.
- Out-of-range address (addr >= NUM_ENTRIES): writes are dropped; reads return 0 with dout_valid asserted normally.
- Same-cycle, same in-range address, both ports accepted:
  - Both reads: no collision; both ports return the same data.
  - Write and read: the reading port gets the old (pre-write) data; the write completes; collision=1 on the next cycle.
  - Both write: per byte, A wins where both enable the lane, otherwise the enabling port's byte is stored; collision=1 on the next cycle.
- Back-to-back: one request per port per cycle, sustained with no bubbles. With READ_LATENCY=2, two reads per port are in flight.

Decomposition:
- Shared package tdp_ram_pkg:
  - FSM state enum (RESET, CLEAR, READY).
  - Legal READ_LATENCY values.
  - Function computing NUM_BYTES.
- Sub-module tdp_ram_core: plain unreset storage array with two byte-enable write ports and two registered read ports, written so vendor tools infer block RAM.
- Top level tdp_ram_bytewise: clear FSM and counter, request gating, collision compare and merge, second latency stage and valid pipeline.

Test Plan:
1. Clear sweep: NUM_ENTRIES=16, CLEAR_ON_RESET=1; release reset_n -> init_done rises exactly 16 cycles later. Read all 16 addresses on port B -> every dout=0x00000000. A read issued during the sweep produces no dout_valid.
2. Byte enables: A writes 0xAABBCCDD to addr 5 with we=4'b1111, then 0x11223344 with we=4'b0101 -> B reads 0xAA22CC44 at addr 5. Latency 1 cycle (READ_LATENCY=1), 2 cycles (READ_LATENCY=2).
3. Read/write collision: mem[7]=0x1; same cycle, A writes 0x2 to addr 7 while B reads addr 7 -> B dout=0x1 and collision pulses for one cycle. The next read of addr 7 returns 0x2.
4. Write/write merge: same cycle, A writes 0x000000FF with we=4'b0011 and B writes 0xFFFF0000 with we=4'b1110 to addr 3 -> mem[3]=0xFFFF00FF. collision=1.
5. Streaming and no-change: A reads addr 0..7 on consecutive cycles -> 8 consecutive dout_valid pulses in order. An A write interleaved at cycle 4 leaves portA_dout holding the prior read value and inserts no valid for that cycle.
6. Asynchronous reset mid-sweep: assert reset_n low at sweep address 9 -> init_done, dout and dout_valid drop immediately. On release, the sweep restarts and takes the full NUM_ENTRIES cycles. An out-of-range read (NUM_ENTRIES=12, addr 13) returns 0 with dout_valid=1.
